scope_trigger_capture: RTL and testbench
========================================

Name: scope_trigger_capture

Overview:
- Consumes the 12-bit sample stream from the I2C ADC front end and captures one frame of DEPTH samples around a trigger event.
- The frame holds PRE_TRIG samples taken before the trigger and the rest taken after it.
- Holds the frame in an internal circular buffer and presents it to the display renderer through a random-access read port indexed from frame start.
- Sits between the ADC controller and the waveform drawing logic.

Parameters:
- DATA_W, 12: sample width.
- ADDR_W, 8: buffer address width. DEPTH = 2**ADDR_W.
- PRE_TRIG, 64: samples kept before the trigger sample. Legal range is 1..DEPTH-2.
- AUTO_TIMEOUT, 1024: count of valid samples in WAIT_TRIG after which auto mode forces a trigger.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sample_in  in  DATA_W  ADC sample.
- sample_valid  in  1  one-cycle strobe; sample_in is valid when high.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_slope  in  1  0 = rising, 1 = falling.
- trig_auto  in  1  1 = auto mode (force trigger on timeout), 0 = normal.
- arm  in  1  one-cycle pulse that starts a capture.
- rd_addr  in  ADDR_W  logical frame index; 0 = oldest sample.
- rd_data  out  DATA_W  frame sample, registered.
- busy  out  1  capture in progress (PRE_FILL, WAIT_TRIG, POST_FILL).
- frame_ready  out  1  high in DONE.
- forced  out  1  last frame was triggered by auto timeout.
- trig_addr  out  ADDR_W  physical address of the trigger sample.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values:
  - state IDLE.
  - busy, frame_ready, forced, trig_addr, rd_data: 0.
  - Write pointer, counters and prev_valid: 0.
  - Buffer contents are not reset.
- All state updates occur only on cycles with sample_valid=1, except arm handling and reads.

States:
- IDLE: no writes. arm -> PRE_FILL.
- PRE_FILL:
  - Each valid sample is written at wr_ptr, then wr_ptr++ and pre_cnt++.
  - When the PRE_TRIG-th sample is written -> WAIT_TRIG.
  - Triggers are ignored in this state.
- WAIT_TRIG:
  - Each valid sample is written at wr_ptr and wr_ptr++, wrapping mod DEPTH.
  - A trigger fires on the same valid sample when prev_valid=1 and:
    - rising: prev < trig_level and sample_in >= trig_level;
    - falling: prev > trig_level and sample_in <= trig_level.
  - In auto mode, to_cnt counts valid samples in this state. When trig_auto=1 and the current sample is the AUTO_TIMEOUT-th with no real trigger, that sample is the trigger and forced <= 1.
  - On trigger: trig_addr <= wr_ptr (address of the triggering sample), post_cnt <= 0, -> POST_FILL.
  - In normal mode the block stays here indefinitely.
- POST_FILL:
  - Writes continue.
  - After DEPTH-PRE_TRIG-1 further samples -> DONE.
- DONE:
  - Writes stop; frame_ready=1, busy=0.
  - arm -> PRE_FILL.

Trigger history:
- prev is updated with every valid sample in PRE_FILL, WAIT_TRIG and POST_FILL.
- prev_valid is cleared on arm and set on the first valid sample after it.

Arm handling:
- arm in any state clears wr_ptr, pre_cnt, to_cnt, forced, frame_ready and prev_valid, and enters PRE_FILL. This restarts any capture in progress.
- arm coinciding with sample_valid: arm wins. That sample is not written; capture starts with the next valid sample.

Read port:
- Physical address = (trig_addr - PRE_TRIG + rd_addr) mod DEPTH.
- rd_data appears one clock after rd_addr.
- Reads are permitted in any state; data is guaranteed consistent only in DONE.
- Frame layout: logical index PRE_TRIG is always the trigger sample, and logical DEPTH-1 is the last sample written.
- Arithmetic is ADDR_W-bit unsigned with natural wrap.

Reset mid-capture: returns to IDLE immediately; a new arm is required.

Test Plan (DEPTH=16, PRE_TRIG=4, AUTO_TIMEOUT=32):
- Rising ramp: arm, then sample_in = 0,1,2,… each valid, level=10, slope=0.
  - Trigger on sample 10; trig_addr=10; frame_ready after sample 21.
  - rd_addr 0..15 -> 6..21; forced=0.
- Falling: arm, samples 100 down by 1, level=90, slope=1.
  - Trigger on sample value 90 (sample index 10).
  - rd_addr 4 -> 90, rd_addr 0 -> 94, rd_addr 15 -> 79.
- Auto timeout: constant 5, level=100, trig_auto=1.
  - Forced trigger on the 32nd valid sample in WAIT_TRIG; forced=1; frame_ready 11 valid samples later; all rd_data=5.
- Normal mode, no crossing: constant 5, trig_auto=0, 200 samples.
  - busy=1, frame_ready=0, state stays in WAIT_TRIG.
- Re-arm mid-POST_FILL, with arm coincident with sample_valid:
  - That sample is not written; pre-fill restarts.
  - A ramp from 50 upward with level=60 gives trig_addr=10, rd_addr 0 -> 56.
- Async rst asserted between clock edges during WAIT_TRIG:
  - busy, frame_ready, forced and rd_data read 0 immediately, without waiting for a clock edge.
  - After rst release no capture runs until arm.

Source files
------------

// File: rtl/scope_trigger_capture.sv
// Trigger-and-capture block for the scope: records a frame of DEPTH samples
// around a level crossing and serves it through a registered read port.
module scope_trigger_capture #(
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 8,
    parameter int PRE_TRIG     = 64,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              trig_auto,
    input  logic              arm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_ready,
    output logic              forced,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
    localparam int TO_W     = $clog2(AUTO_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST_FILL,
        DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              wr_en;
    logic              trig_fire;
    logic              real_trig;
    logic              auto_hit;
    logic [ADDR_W-1:0] rd_phys;

    // Edge detection needs a sample from the same capture, hence prev_valid.
    assign real_trig = prev_valid &&
        (trig_slope ? (prev > trig_level && sample_in <= trig_level)
                    : (prev < trig_level && sample_in >= trig_level));
    assign auto_hit  = trig_auto && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        frame_ready = 1'b0;
        wr_en       = 1'b0;
        trig_fire   = 1'b0;
        unique case (state)
            IDLE: ;
            PRE_FILL: begin
                busy  = 1'b1;
                wr_en = sample_valid;
                if (sample_valid && pre_cnt == ADDR_W'(PRE_TRIG - 1))
                    state_next = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                busy      = 1'b1;
                wr_en     = sample_valid;
                trig_fire = sample_valid && (real_trig || auto_hit);
                if (trig_fire)
                    state_next = POST_FILL;
            end
            POST_FILL: begin
                busy  = 1'b1;
                wr_en = sample_valid;
                if (sample_valid && post_cnt == ADDR_W'(POST_LEN - 1))
                    state_next = DONE;
            end
            DONE: frame_ready = 1'b1;
            default: state_next = IDLE;
        endcase
        // arm overrides everything, including a coincident sample
        if (arm) begin
            state_next = PRE_FILL;
            wr_en      = 1'b0;
            trig_fire  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            to_cnt     <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            forced     <= 1'b0;
            trig_addr  <= '0;
        end else begin
            state <= state_next;
            if (arm) begin
                wr_ptr     <= '0;
                pre_cnt    <= '0;
                to_cnt     <= '0;
                forced     <= 1'b0;
                prev_valid <= 1'b0;
            end else if (wr_en) begin
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                prev       <= sample_in;
                prev_valid <= 1'b1;
                unique case (state)
                    PRE_FILL: pre_cnt <= pre_cnt + ADDR_W'(1);
                    WAIT_TRIG: begin
                        if (trig_fire) begin
                            trig_addr <= wr_ptr;
                            forced    <= !real_trig;
                            post_cnt  <= '0;
                        end else if (trig_auto) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    POST_FILL: post_cnt <= post_cnt + ADDR_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= sample_in;
    end

    // Logical index 0 is PRE_TRIG samples before the trigger; natural wrap.
    assign rd_phys = trig_addr - ADDR_W'(PRE_TRIG) + rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_phys];
    end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Randomized bench for scope_trigger_capture: a sample-history model predicts
// the frame, and a read-port monitor drains a queue of expected read data.
module tb_scope_trigger_capture;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int PRE    = 4;
    localparam int TO     = 32;
    localparam int POST   = DEPTH - PRE - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] trig_level = '0;
    logic              trig_slope = 1'b0;
    logic              trig_auto = 1'b0;
    logic              arm = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              busy, frame_ready, forced;
    logic [ADDR_W-1:0] trig_addr;

    scope_trigger_capture #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_TRIG(PRE), .AUTO_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_level(trig_level), .trig_slope(trig_slope), .trig_auto(trig_auto),
        .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .frame_ready(frame_ready), .forced(forced), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: every sample accepted since the last arm, in arrival order
    int hist[$];
    int exp_q[$];
    int addr_q[$];
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // trigger index within hist, or -1; f reports an auto-forced trigger
    function automatic int find_trig(output bit f);
        f = 1'b0;
        for (int i = PRE; i < hist.size(); i++) begin
            bit hit;
            if (trig_slope)
                hit = hist[i-1] > int'(trig_level) && hist[i] <= int'(trig_level);
            else
                hit = hist[i-1] < int'(trig_level) && hist[i] >= int'(trig_level);
            if (hit) return i;
            if (trig_auto && (i - PRE + 1) == TO) begin
                f = 1'b1;
                return i;
            end
        end
        return -1;
    endfunction

    function automatic bit model_done();
        bit f;
        int t;
        t = find_trig(f);
        return t >= 0 && hist.size() >= t + POST + 1;
    endfunction

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input int v);
        sample_in    = DATA_W'(v);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        hist.push_back(v);
        idle($urandom_range(0, 2));
    endtask

    task automatic do_arm(input bit with_sample, input int v);
        arm          = 1'b1;
        sample_valid = with_sample;
        sample_in    = DATA_W'(v);
        @(posedge clk);
        #1;
        arm          = 1'b0;
        sample_valid = 1'b0;
        hist.delete();
    endtask

    task automatic rd(input int a, input int exp);
        rd_addr = ADDR_W'(a);
        rd_req  = 1'b1;
        exp_q.push_back(exp);
        addr_q.push_back(a);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    // feeds from gen until the model says the frame is complete (bounded)
    task automatic run_capture(input int start, input int step, input bit rnd);
        int v = start;
        int n = 0;
        while (!model_done() && n < 200) begin
            feed(rnd ? int'($urandom_range(0, 4095)) : v);
            v += step;
            n++;
        end
        if (!model_done()) begin
            errors++;
            $display("FAIL capture_bound: got %0d samples expected frame completion", n);
        end
    endtask

    // compare status and read every frame slot in a shuffled order
    task automatic check_frame(input string tag);
        bit f;
        int t;
        int s;
        t = find_trig(f);
        chk({tag, "_frame_ready"}, frame_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_forced"}, forced, f);
        chk({tag, "_trig_addr"}, trig_addr, t % DEPTH);
        s = $urandom_range(0, DEPTH - 1);
        for (int j = 0; j < DEPTH; j++) begin
            int k;
            k = (s + j * 7) % DEPTH;
            rd(k, hist[t - PRE + k]);
        end
        idle(2);
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %0d expected no read", rd_data);
            end else begin
                int e;
                int a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                checks++;
                if (int'(rd_data) != e) begin
                    errors++;
                    $display("FAIL rd_data[%0d]: got %0d expected %0d", a, rd_data, e);
                end
            end
        end
    end

    initial begin
        // reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_forced", forced, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        chk("idle_busy", busy, 0);

        // rising ramp
        trig_level = 12'd10; trig_slope = 1'b0; trig_auto = 1'b0;
        do_arm(1'b0, 0);
        chk("arm_busy", busy, 1);
        run_capture(0, 1, 1'b0);
        chk("ramp_trig_abs", trig_addr, 10);
        chk("ramp_len", hist.size(), 22);
        check_frame("ramp");
        rd(0, 6);
        rd(15, 21);

        // falling ramp
        trig_level = 12'd90; trig_slope = 1'b1;
        do_arm(1'b0, 0);
        run_capture(100, -1, 1'b0);
        check_frame("fall");
        rd(4, 90);
        rd(0, 94);
        rd(15, 79);

        // auto timeout on a flat signal
        trig_level = 12'd100; trig_slope = 1'b0; trig_auto = 1'b1;
        do_arm(1'b0, 0);
        run_capture(5, 0, 1'b0);
        chk("auto_forced_abs", forced, 1);
        chk("auto_len", hist.size(), PRE + TO + POST);
        check_frame("auto");

        // normal mode with no crossing never completes
        trig_auto = 1'b0;
        do_arm(1'b0, 0);
        for (int i = 0; i < 200; i++) feed(5);
        chk("norm_busy", busy, 1);
        chk("norm_frame_ready", frame_ready, 0);

        // re-arm during post-fill with a coincident sample
        trig_level = 12'd60;
        do_arm(1'b0, 0);
        for (int i = 0; i < 13; i++) feed(50 + i);
        chk("rearm_pre_busy", busy, 1);
        do_arm(1'b1, 999);
        run_capture(50, 1, 1'b0);
        chk("rearm_trig_abs", trig_addr, 10);
        check_frame("rearm");
        rd(0, 56);

        // randomized captures (auto on so each one terminates)
        trig_auto = 1'b1;
        for (int r = 0; r < 5; r++) begin
            trig_level = DATA_W'($urandom_range(200, 3900));
            trig_slope = 1'($urandom_range(0, 1));
            do_arm(1'b0, 0);
            run_capture(0, 0, 1'b1);
            check_frame("rand");
        end

        // asynchronous reset between clock edges during WAIT_TRIG
        trig_auto = 1'b0; trig_level = 12'd100; trig_slope = 1'b0;
        do_arm(1'b0, 0);
        for (int i = 0; i < 6; i++) feed(5);
        rd_addr = 4'd3;
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_frame_ready", frame_ready, 0);
        chk("arst_forced", forced, 0);
        chk("arst_rd_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) feed(200 + i);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_frame_ready", frame_ready, 0);

        idle(3);
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
